load_unit: RTL

Single-outstanding load execution stage sitting directly downstream of the load queue. Accepts one ready load (address, ROB index, destination physical register, size) per handshake, issues a word-aligned read to the data memory port, extracts and sign/zero-extends the addressed bytes, and presents the result on the writeback bus toward the ROB/CDB. Handles misalignment exceptions without a memory access and supports pipeline flush, draining any already-issued memory request.

---
 rtl/load_unit_if.sv | 53 +++++
 rtl/load_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/load_unit_if.sv
// Load unit bus bundle: load-queue request, data-memory read port and
// writeback toward the ROB/CDB.
interface load_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  parameter int PREG_W = 7
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [ROB_W-1:0]  req_rob_idx;
  logic [PREG_W-1:0] req_dst_preg;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              req_ready;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  logic              flush;

  logic              wb_valid;
  logic [ROB_W-1:0]  wb_rob_idx;
  logic [PREG_W-1:0] wb_dst_preg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;
  logic              wb_ready;

  // Load unit side
  modport slave (
    input  req_valid, req_addr, req_rob_idx, req_dst_preg, req_size, req_unsigned,
    output req_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  flush,
    output wb_valid, wb_rob_idx, wb_dst_preg, wb_data, wb_exception,
    input  wb_ready
  );

  // Environment side (load queue, memory, CDB)
  modport master (
    output req_valid, req_addr, req_rob_idx, req_dst_preg, req_size, req_unsigned,
    input  req_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output flush,
    input  wb_valid, wb_rob_idx, wb_dst_preg, wb_data, wb_exception,
    output wb_ready
  );
endinterface

// File: rtl/load_unit.sv
// Single-outstanding load execution stage: one load in flight, word-aligned
// memory read, byte/half extraction with sign/zero extension, misalignment
// fault without memory access, flush with drain of an issued request.
module load_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  parameter int PREG_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  load_unit_if.slave  lu
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ROB_W-1:0]  r_rob;
  logic [PREG_W-1:0] r_preg;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [DATA_W-1:0] r_data;
  logic              r_exc;

  logic              w_accept;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;

  // Accept only in IDLE; a flush or reset in the same cycle blocks the handshake.
  assign lu.req_ready = (r_state == S_IDLE) & ~lu.flush & ~reset;
  assign w_accept     = lu.req_valid & lu.req_ready;

  // Half needs addr[0]=0; word and the reserved size need addr[1:0]=0.
  assign w_misaligned = ((lu.req_size == 2'b01) & lu.req_addr[0]) |
                        (lu.req_size[1] & (lu.req_addr[1:0] != 2'b00));

  // Byte/half lane selection and extension from the latched request.
  always_comb begin
    w_shift = lu.mem_resp_data >> {r_addr[1:0], 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_addr[1] ? lu.mem_resp_data[31:16] : lu.mem_resp_data[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{w_byte[7] & ~r_uns}}, w_byte};
      2'b01:   w_ext = {{16{w_half[15] & ~r_uns}}, w_half};
      default: w_ext = lu.mem_resp_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: flush outranks every other event; an issued request is drained.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_misaligned ? S_WB : S_REQ;
      end
      S_REQ: begin
        if (lu.flush)              w_next = lu.mem_req_ready ? S_DRAIN : S_IDLE;
        else if (lu.mem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (lu.flush)               w_next = lu.mem_resp_valid ? S_IDLE : S_DRAIN;
        else if (lu.mem_resp_valid) w_next = S_WB;
      end
      S_WB: begin
        if (lu.flush || lu.wb_ready) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (lu.mem_resp_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch request fields on accept; capture extracted data on a live response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_rob  <= '0;
      r_preg <= '0;
      r_size <= '0;
      r_uns  <= 1'b0;
      r_data <= '0;
      r_exc  <= 1'b0;
    end else if (w_accept) begin
      r_addr <= lu.req_addr;
      r_rob  <= lu.req_rob_idx;
      r_preg <= lu.req_dst_preg;
      r_size <= lu.req_size;
      r_uns  <= lu.req_unsigned;
      r_data <= '0;
      r_exc  <= w_misaligned;
    end else if (r_state == S_WAIT && lu.mem_resp_valid && !lu.flush) begin
      r_data <= w_ext;
    end
  end

  assign lu.mem_req_valid = (r_state == S_REQ);
  assign lu.mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign lu.wb_valid      = (r_state == S_WB);
  assign lu.wb_rob_idx    = r_rob;
  assign lu.wb_dst_preg   = r_preg;
  assign lu.wb_data       = r_data;
  assign lu.wb_exception  = r_exc;

endmodule
